// File: rtl/biquad_stream.sv
// biquad_stream: streaming direct-form-I biquad over an Avalon-MM master.
// COUNT samples are read from SRC, filtered, and written to DST. Control and
// status live in a small Avalon slave register file; irq is high while DONE.
//
// Optional build macro: BIQUAD_ROUND_EN adds half an LSB before the output
// shift (round half up). Without it the shift truncates toward -inf.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   sdaddress/sdread/sdwrite/       master request (byte address, strobes,
//   sdwritedata/sdwaitrequest       write data, stall)
//   sdreaddata/sdreaddatavalid      master read return
//   slave_address/read/write/       register file access, 1-cycle read latency
//   writedata/readdata
//   irq                             level interrupt, high while DONE
module biquad_stream #(
  parameter int DATA_W          = 32,
  parameter int COEFF_W         = 16,
  parameter int COEFF_FRAC      = 14,
  parameter int ADDR_W          = 24,
  parameter int WORD_SKIP       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] sdaddress,
  output logic              sdread,
  input  logic [DATA_W-1:0] sdreaddata,
  input  logic              sdreaddatavalid,
  input  logic              sdwaitrequest,
  output logic              sdwrite,
  output logic [DATA_W-1:0] sdwritedata,
  input  logic [3:0]        slave_address,
  input  logic              slave_read,
  output logic [31:0]       slave_readdata,
  input  logic              slave_write,
  input  logic [31:0]       slave_writedata,
  output logic              irq
);
  localparam int ACC_W = DATA_W + COEFF_W + 3;
  localparam int PW    = $clog2(MAX_OUTSTANDING);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state;

  logic                      bypass, ovf;
  logic [ADDR_W-1:0]         src, dst;
  logic [31:0]               count, processed, rd_issued, rd_consumed;
  logic signed [COEFF_W-1:0] b0, b1, b2, a1, a2;
  logic signed [DATA_W-1:0]  x1, x2, y1, y2, x_s1, res_data;
  logic signed [ACC_W-1:0]   acc;
  logic                      acc_vld, res_vld;

  // Read-data FIFO; the read credit limit guarantees it never overflows.
  logic [DATA_W-1:0] fifo [MAX_OUTSTANDING];
  logic [PW:0]       f_wp, f_rp;

  logic busy, push, pop, rd_ok, req_acc, wr_acc, start, sat_hi, sat_lo;
  logic signed [DATA_W-1:0] x_head, y_sat, y_new;
  logic signed [ACC_W-1:0]  acc_next, acc_rnd, acc_sh;
  logic [31:0] rd_mux;

  function automatic logic signed [ACC_W-1:0] mul(input logic signed [COEFF_W-1:0] c,
                                                  input logic signed [DATA_W-1:0] d);
    logic signed [ACC_W-1:0] ce, de;
    ce = c;
    de = d;
    return ce * de;
  endfunction

  assign busy    = (state == ST_RUN);
  assign irq     = (state == ST_DONE);
  assign push    = busy && sdreaddatavalid;
  assign x_head  = fifo[f_rp[PW-1:0]];
  // One sample in flight through acc/result at a time so y1 is always current.
  assign pop     = busy && (f_wp != f_rp) && !acc_vld && !res_vld;
  assign rd_ok   = busy && (rd_issued < count) &&
                   ((rd_issued - rd_consumed) < 32'(MAX_OUTSTANDING));
  assign req_acc = (sdread || sdwrite) && !sdwaitrequest;
  assign wr_acc  = sdwrite && !sdwaitrequest;
  assign start   = slave_write && (slave_address == 4'd0) && slave_writedata[0];

  assign acc_next = mul(b0, x_head) + mul(b1, x1) + mul(b2, x2) - mul(a1, y1) - mul(a2, y2);

`ifdef BIQUAD_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEFF_FRAC - 1);
  assign acc_rnd = acc + RND;
`else
  assign acc_rnd = acc;
`endif
  assign acc_sh = acc_rnd >>> COEFF_FRAC;
  // Result fits DATA_W only if every bit above the DATA_W sign bit matches it.
  assign sat_hi = !acc_sh[ACC_W-1] && (|acc_sh[ACC_W-2:DATA_W-1]);
  assign sat_lo =  acc_sh[ACC_W-1] && !(&acc_sh[ACC_W-2:DATA_W-1]);
  assign y_sat  = sat_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                  sat_lo ? {1'b1, {(DATA_W-1){1'b0}}} : acc_sh[DATA_W-1:0];
  assign y_new  = bypass ? x_s1 : y_sat;

  always_comb begin
    rd_mux = '0;
    case (slave_address)
      4'd0:    rd_mux = {30'd0, bypass, 1'b0};
      4'd1:    rd_mux = 32'(src);
      4'd2:    rd_mux = 32'(dst);
      4'd3:    rd_mux = count;
      4'd4:    rd_mux = 32'(b0);
      4'd5:    rd_mux = 32'(b1);
      4'd6:    rd_mux = 32'(b2);
      4'd7:    rd_mux = 32'(a1);
      4'd8:    rd_mux = 32'(a2);
      4'd9:    rd_mux = {29'd0, ovf, irq, busy};
      4'd10:   rd_mux = processed;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk)
    if (push) fifo[f_wp[PW-1:0]] <= sdreaddata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      {bypass, ovf, acc_vld, res_vld, sdread, sdwrite} <= '0;
      {src, dst, count, processed, rd_issued, rd_consumed} <= '0;
      {b0, b1, b2, a1, a2} <= '0;
      {x1, x2, y1, y2, x_s1, res_data, acc} <= '0;
      {f_wp, f_rp} <= '0;
      sdaddress      <= '0;
      sdwritedata    <= '0;
      slave_readdata <= '0;
    end else begin
      if (slave_read) slave_readdata <= rd_mux;

      if (slave_write && !busy) begin
        case (slave_address)
          4'd0: bypass <= slave_writedata[1];
          4'd1: src    <= slave_writedata[ADDR_W-1:0];
          4'd2: dst    <= slave_writedata[ADDR_W-1:0];
          4'd3: count  <= slave_writedata;
          4'd4: b0     <= slave_writedata[COEFF_W-1:0];
          4'd5: b1     <= slave_writedata[COEFF_W-1:0];
          4'd6: b2     <= slave_writedata[COEFF_W-1:0];
          4'd7: a1     <= slave_writedata[COEFF_W-1:0];
          4'd8: a2     <= slave_writedata[COEFF_W-1:0];
          default: ;
        endcase
      end
      if (slave_write && slave_address == 4'd9 && slave_writedata[2]) ovf <= 1'b0;

      if (push) f_wp <= f_wp + 1'b1;

      // Master port: one request at a time, held until accepted; a pending
      // result write goes ahead of a new read.
      if (req_acc) begin
        sdread  <= 1'b0;
        sdwrite <= 1'b0;
      end else if (!sdread && !sdwrite) begin
        if (res_vld) begin
          sdwrite     <= 1'b1;
          sdaddress   <= dst + ADDR_W'(processed * 32'(WORD_SKIP));
          sdwritedata <= res_data;
        end else if (rd_ok) begin
          sdread    <= 1'b1;
          sdaddress <= src + ADDR_W'(rd_issued * 32'(WORD_SKIP));
          rd_issued <= rd_issued + 32'd1;
        end
      end
      if (wr_acc) begin
        res_vld   <= 1'b0;
        processed <= processed + 32'd1;
      end

      // Stage 1: pop and register the accumulator.
      acc_vld <= pop;
      if (pop) begin
        acc         <= acc_next;
        x_s1        <= x_head;
        f_rp        <= f_rp + 1'b1;
        rd_consumed <= rd_consumed + 32'd1;
      end
      // Stage 2: shift/saturate into the result register, advance history.
      if (acc_vld) begin
        res_data <= y_new;
        res_vld  <= 1'b1;
        x2 <= x1;
        x1 <= x_s1;
        y2 <= y1;
        y1 <= y_new;
        if (!bypass && (sat_hi || sat_lo)) ovf <= 1'b1;
      end

      case (state)
        ST_IDLE: if (start) begin
          state <= (count == 32'd0) ? ST_DONE : ST_RUN;
          {x1, x2, y1, y2} <= '0;
          {processed, rd_issued, rd_consumed} <= '0;
          {f_wp, f_rp} <= '0;
          acc_vld <= 1'b0;
          res_vld <= 1'b0;
        end
        ST_RUN: if (wr_acc && (processed + 32'd1 == count)) state <= ST_DONE;
        ST_DONE: if (slave_write && slave_address == 4'd9 && slave_writedata[1])
          state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_biquad_stream.sv
// Scoreboard bench for biquad_stream: a bus model serves reads from a sparse
// memory, optionally stalls, and compares every accepted write against
// results queued by a reference biquad model when each run is programmed.
module tb_biquad_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] sdaddress;
  logic        sdread, sdwrite;
  logic [31:0] sdreaddata = '0;
  logic        sdreaddatavalid = 1'b0;
  logic        sdwaitrequest = 1'b0;
  logic [31:0] sdwritedata;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0, slave_write = 1'b0;
  logic [31:0] slave_readdata, slave_writedata = '0;
  logic        irq;

  biquad_stream dut (
    .clk(clk), .reset(reset),
    .sdaddress(sdaddress), .sdread(sdread), .sdreaddata(sdreaddata),
    .sdreaddatavalid(sdreaddatavalid), .sdwaitrequest(sdwaitrequest),
    .sdwrite(sdwrite), .sdwritedata(sdwritedata),
    .slave_address(slave_address), .slave_read(slave_read),
    .slave_readdata(slave_readdata), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct { logic [23:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [31:0] d; int due; } rsp_t;
  wr_t         exp_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [int];
  logic [31:0] smp[$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus model state.
  bit          in_req = 0, stall_en = 0, h_rd;
  int          req_n = 0, n_req_total = 0, stall_left = 0, rd_idx = 0;
  int          wr_seen = 0, max_inflight = 0;
  logic [23:0] src_base = '0, h_addr;
  logic [31:0] h_data;
  localparam int LAT = 3;

  always @(negedge clk) begin
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      sdreaddatavalid = 1'b1;
      sdreaddata      = rsp_q[0].d;
      void'(rsp_q.pop_front());
    end else begin
      sdreaddatavalid = 1'b0;
      sdreaddata      = '0;
    end
    if (reset) begin
      in_req        = 0;
      sdwaitrequest = 1'b0;
    end else if (sdread || sdwrite) begin
      if (!in_req) begin
        in_req = 1;
        req_n++;
        n_req_total++;
        stall_left = (stall_en && (req_n % 3 == 0)) ? 5 : 0;
        h_addr = sdaddress;
        h_data = sdwritedata;
        h_rd   = sdread;
        chk("rd_wr_excl", sdread && sdwrite, 0);
      end else begin
        chk("hold_addr", sdaddress, h_addr);
        chk("hold_strobe", sdread, h_rd);
        if (!h_rd) chk("hold_data", sdwritedata, h_data);
      end
      if (stall_left > 0) begin
        sdwaitrequest = 1'b1;
        stall_left--;
      end else begin
        sdwaitrequest = 1'b0;
        in_req = 0;
        if (sdread) begin
          chk("rd_addr", sdaddress, 24'(int'(src_base) + rd_idx * 4));
          rd_idx++;
          rsp_q.push_back('{mem.exists(int'(sdaddress)) ? mem[int'(sdaddress)] : 32'hDEADBEEF,
                            cyc + LAT});
          if (rsp_q.size() > max_inflight) max_inflight = rsp_q.size();
        end else begin
          wr_t e;
          wr_seen++;
          if (exp_q.size() == 0) chk("wr_unexpected", sdaddress, 24'hFFFFFF);
          else begin
            e = exp_q.pop_front();
            chk("wr_addr", sdaddress, e.a);
            chk("wr_data", sdwritedata, e.d);
          end
        end
      end
    end else begin
      in_req        = 0;
      sdwaitrequest = 1'b0;
    end
  end

  // Reference biquad, 64-bit arithmetic.
  longint mx1, mx2, my1, my2;
  bit     m_ovf;
  function automatic logic [31:0] model(input logic [31:0] x, input bit byp,
                                        input longint c0, c1, c2, d1, d2);
    longint xs, acc, y;
    xs  = longint'($signed(x));
    acc = c0 * xs + c1 * mx1 + c2 * mx2 - d1 * my1 - d2 * my2;
`ifdef BIQUAD_ROUND_EN
    acc = acc + 64'sd8192;
`endif
    y = acc >>> 14;
    if (byp) y = xs;
    else if (y > 64'sd2147483647) begin y = 64'sd2147483647; m_ovf = 1; end
    else if (y < -64'sd2147483648) begin y = -64'sd2147483648; m_ovf = 1; end
    mx2 = mx1; mx1 = xs; my2 = my1; my1 = y;
    return y[31:0];
  endfunction

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic prog(input logic [23:0] s, d, input int n, input bit byp,
                      input int c0, c1, c2, c3, c4, input bit stall);
    reg_wr(4'd9, 32'h4);
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0; m_ovf = 0;
    for (int i = 0; i < n; i++) begin
      mem[int'(s) + 4 * i] = smp[i];
      exp_q.push_back('{24'(int'(d) + 4 * i), model(smp[i], byp, c0, c1, c2, c3, c4)});
    end
    src_base = s; rd_idx = 0; req_n = 0; stall_en = stall; wr_seen = 0; max_inflight = 0;
    reg_wr(4'd1, 32'(s)); reg_wr(4'd2, 32'(d)); reg_wr(4'd3, 32'(n));
    reg_wr(4'd4, 32'(c0)); reg_wr(4'd5, 32'(c1)); reg_wr(4'd6, 32'(c2));
    reg_wr(4'd7, 32'(c3)); reg_wr(4'd8, 32'(c4));
    reg_wr(4'd0, {30'd0, byp, 1'b1});
  endtask

  task automatic do_run(input logic [23:0] s, d, input int n, input bit byp,
                        input int c0, c1, c2, c3, c4, input bit stall,
                        output logic [31:0] st);
    logic [31:0] v;
    int t = 0;
    prog(s, d, n, byp, c0, c1, c2, c3, c4, stall);
    while (!irq && t < 3000) begin @(negedge clk); t++; end
    chk("done_irq", irq, 1);
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    reg_rd(4'd10, v);
    chk("processed", v, n);
    reg_rd(4'd9, st);
    reg_wr(4'd9, 32'h2);
    chk("irq_cleared", irq, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] st, v;
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sdread", sdread, 0);
    chk("rst_sdwrite", sdwrite, 0);
    chk("rst_sdaddress", sdaddress, 0);
    chk("rst_sdwritedata", sdwritedata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_readdata", slave_readdata, 0);
    reset = 1'b0;
    reg_rd(4'd9, v);  chk("rst_status", v, 0);
    reg_rd(4'd3, v);  chk("rst_count", v, 0);
    reg_rd(4'd12, v); chk("unmapped", v, 0);

    // Bypass copy.
    smp = {32'd5, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'd0};
    do_run(24'h000100, 24'h000800, 4, 1'b1, 0, 0, 0, 0, 0, 1'b0, st);
    chk("byp_status", st, 32'h2);

    // Impulse: y = x + y1/2 -> 1000, 500, 250, 125.
    smp = {32'd1000, 32'd0, 32'd0, 32'd0};
    do_run(24'h000200, 24'h000900, 4, 1'b0, 16384, 0, 0, -8192, 0, 1'b0, st);
    chk("imp_status", st, 32'h2);

    // Saturation, then sticky OVF clear.
    smp = {32'h7FFFFFFF};
    do_run(24'h000300, 24'h000A00, 1, 1'b0, 32767, 0, 0, 0, 0, 1'b0, st);
    chk("sat_status", st, 32'h6);
    reg_wr(4'd9, 32'h4);
    reg_rd(4'd9, v);
    chk("ovf_cleared", v, 0);

    // Full filter under backpressure.
    smp.delete();
    for (int i = 0; i < 20; i++) smp.push_back(32'($urandom_range(0, 4000000)) - 32'd2000000);
    do_run(24'h001000, 24'h002000, 20, 1'b0, 8192, 4096, -2048, -4096, 1024, 1'b1, st);
    chk("bp_max_inflight_ok", max_inflight <= 8, 1);
    stall_en = 0;

    // Reset mid-run with reads outstanding.
    smp.delete();
    for (int i = 0; i < 8; i++) smp.push_back(32'(i * 1000 + 7));
    prog(24'h003000, 24'h004000, 8, 1'b0, 16384, 0, 0, 0, 0, 1'b0);
    reg_rd(4'd9, v);
    chk("run_busy", v, 32'h1);
    reg_wr(4'd3, 32'd99);
    reg_rd(4'd3, v);
    chk("busy_write_ignored", v, 8);
    t = 0;
    while (wr_seen < 3 && t < 2000) begin @(negedge clk); t++; end
    chk("mid_writes_seen", wr_seen >= 3, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_sdread", sdread, 0);
    chk("mid_sdwrite", sdwrite, 0);
    chk("mid_sdaddress", sdaddress, 0);
    chk("mid_sdwritedata", sdwritedata, 0);
    chk("mid_irq", irq, 0);
    chk("mid_readdata", slave_readdata, 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (12) @(negedge clk);
    smp = {32'd300, 32'hFFFFFF00};
    do_run(24'h005000, 24'h006000, 2, 1'b0, 8192, 8192, 0, 0, 0, 1'b0, st);
    chk("restart_status", st, 32'h2);

    // COUNT=0: immediate DONE, no traffic, second START ignored.
    n_req_total = 0;
    reg_wr(4'd3, 32'd0);
    reg_wr(4'd0, 32'h1);
    chk("cnt0_irq", irq, 1);
    reg_wr(4'd3, 32'd3);
    reg_wr(4'd0, 32'h1);
    repeat (20) @(negedge clk);
    chk("cnt0_irq_held", irq, 1);
    chk("cnt0_no_traffic", n_req_total, 0);
    reg_rd(4'd9, v);
    chk("cnt0_status", v, 32'h2);
    reg_wr(4'd9, 32'h2);
    chk("cnt0_irq_clr", irq, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
